button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/board_pkg.sv | 9 +
 rtl/debounce_channel.sv | 51 +++++
 rtl/button_debounce.sv | 31 +++
 tb/tb_button_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared board timing defaults and counter-width helper.
// No ports; imported by debounce_channel and button_debounce.
package board_pkg;
    localparam int DEFAULT_N_BTN = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel (synchronizer, stability counter, level, edge pulses).
// Ports: clk, rst (async active-high), raw_i (async pin), level_o (debounced state),
//        press_o / release_o (one-cycle pulses on accepted 0->1 / 1->0).
module debounce_channel
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, press_q, press_d, release_q, release_d;
    logic differ, accept;
    always_comb begin
        sync_d = {sync_q[0], raw_i ^ ACTIVE_LOW};
        differ = sync_q[1] != level_q;
        // accepting on the last count clears the counter in the same edge
        accept = differ && (cnt_q == LAST);
        cnt_d = (differ && !accept) ? cnt_q + 1'b1 : '0;
        level_d = accept ? sync_q[1] : level_q;
        press_d = accept && sync_q[1];
        release_d = accept && !sync_q[1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            release_q <= release_d;
        end
    end
    assign level_o = level_q;
    assign press_o = press_q;
    assign release_o = release_q;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: N_BTN independent debounced button channels.
// Ports: clk, rst (async active-high), btn_raw (async pins), btn_level (debounced state),
//        btn_press / btn_release (one-cycle pulses per channel).
module button_debounce
    import board_pkg::*;
#(
    parameter int N_BTN = DEFAULT_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .raw_i(btn_raw[g]),
            .level_o(btn_level[g]),
            .press_o(btn_press[g]),
            .release_o(btn_release[g])
        );
    end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed checks of button_debounce with DEBOUNCE_CYCLES=4, N_BTN=3.
module tb_button_debounce;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] raw, level, press, rel;
    logic [2:0] raw2, level2, press2, rel2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_debounce #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .btn_raw(raw),
        .btn_level(level), .btn_press(press), .btn_release(rel)
    );

    button_debounce #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .btn_raw(raw2),
        .btn_level(level2), .btn_press(press2), .btn_release(rel2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = 3'b000;
        raw2 = 3'b111;
        step();
        step();
        checks++;
        if ({level, press, rel} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {level, press, rel});
        end
        checks++;
        if ({level2, press2, rel2} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs_al got=%b want=0", {level2, press2, rel2});
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if ({level, press, rel} !== 9'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=0", {level, press, rel});
        end
    endtask

    task automatic test_press();
        raw[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (level[0] !== (i >= 6) || press[0] !== (i == 6) || rel[0] !== 1'b0) begin
                failures++;
                $display("FAIL press_ch0 cyc=%0d level=%b press=%b rel=%b want level=%b press=%b",
                         i, level[0], press[0], rel[0], i >= 6, i == 6);
            end
        end
        raw[0] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (level[0] !== (i < 6) || rel[0] !== (i == 6) || press[0] !== 1'b0) begin
                failures++;
                $display("FAIL release_ch0 cyc=%0d level=%b rel=%b press=%b want level=%b rel=%b",
                         i, level[0], rel[0], press[0], i < 6, i == 6);
            end
        end
    endtask

    task automatic test_short_pulse();
        int bad = 0;
        raw[1] = 1'b1;
        step();
        step();
        step();
        raw[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (level[1] !== 1'b0 || press[1] !== 1'b0 || rel[1] !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL short_pulse_rejected bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            raw[2] = (i % 2 == 0);
            step();
            if (press[2] === 1'b1) pulses++;
        end
        raw[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (press[2] === 1'b1) pulses++;
            checks++;
            if (press[2] !== (i == 6)) begin
                failures++;
                $display("FAIL bounce_press cyc=%0d got=%b want=%b", i, press[2], i == 6);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL bounce_pulse_count got=%0d want=1", pulses);
        end
        raw[2] = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (level !== 3'b000) begin
            failures++;
            $display("FAIL bounce_return_idle got=%b want=000", level);
        end
    endtask

    task automatic test_simultaneous();
        raw = 3'b111;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (press !== ((i == 6) ? 3'b111 : 3'b000) || (press & rel) !== 3'b000) begin
                failures++;
                $display("FAIL simul_press cyc=%0d got=%b rel=%b want=%b",
                         i, press, rel, (i == 6) ? 3'b111 : 3'b000);
            end
        end
        raw = 3'b000;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (rel !== ((i == 6) ? 3'b111 : 3'b000) || (press & rel) !== 3'b000) begin
                failures++;
                $display("FAIL simul_release cyc=%0d got=%b press=%b want=%b",
                         i, rel, press, (i == 6) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_reset_mid();
        raw = 3'b010;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (level !== 3'b010) begin
            failures++;
            $display("FAIL mid_setup_level got=%b want=010", level);
        end
        raw = 3'b011;
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({level, press, rel} !== 9'b0) begin
            failures++;
            $display("FAIL mid_reset_immediate got=%b want=0", {level, press, rel});
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (press !== ((i == 6) ? 3'b011 : 3'b000) || rel !== 3'b000) begin
                failures++;
                $display("FAIL mid_reset_repress cyc=%0d press=%b rel=%b want press=%b",
                         i, press, rel, (i == 6) ? 3'b011 : 3'b000);
            end
        end
        raw = 3'b000;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_active_low();
        checks++;
        if (level2 !== 3'b000 || press2 !== 3'b000) begin
            failures++;
            $display("FAIL al_idle_high level=%b press=%b want 000", level2, press2);
        end
        raw2 = 3'b110;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (press2 !== ((i == 6) ? 3'b001 : 3'b000) || level2 !== ((i >= 6) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL al_press cyc=%0d press=%b level=%b want press=%b",
                         i, press2, level2, (i == 6) ? 3'b001 : 3'b000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_short_pulse();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
